// File: rtl/pe_gene_fetch_ctrl_if.sv
// Genome-memory read port and parent gene-queue ports
// for the PE gene fetch sequencer.
interface pe_gene_fetch_ctrl_if #(
  parameter int GENE_SZ = 64,
  parameter int ADDR_SZ = 10
);
  logic               mem_rd_en;
  logic [ADDR_SZ-1:0] mem_addr;
  logic [GENE_SZ-1:0] mem_rd_data;
  logic               g1_pop;
  logic               g2_pop;
  logic               g1_wr;
  logic [GENE_SZ-1:0] g1_data;
  logic               g1_last;
  logic               g2_wr;
  logic [GENE_SZ-1:0] g2_data;
  logic               g2_last;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    input  g1_pop, g2_pop,
    output g1_wr, g1_data, g1_last,
    output g2_wr, g2_data, g2_last
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    output g1_pop, g2_pop,
    input  g1_wr, g1_data, g1_last,
    input  g2_wr, g2_data, g2_last
  );
endinterface

// File: rtl/pe_gene_fetch_ctrl.sv
// Fetch sequencer: shares one genome read port between two
// parent gene streams with credit flow control and round-robin.
module pe_gene_fetch_ctrl #(
  parameter int GENE_SZ = 64,
  parameter int ADDR_SZ = 10,
  parameter int CNT_SZ  = 8,
  parameter int Q_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_SZ-1:0] p1_base,
  input  logic [CNT_SZ-1:0]  p1_len,
  input  logic [ADDR_SZ-1:0] p2_base,
  input  logic [CNT_SZ-1:0]  p2_len,
  output logic               busy,
  output logic               done,
  output logic               err,
  pe_gene_fetch_ctrl_if.master bus
);
  localparam int CR_SZ = $clog2(Q_DEPTH + 1);
  localparam logic [CR_SZ-1:0] CR_MAX = CR_SZ'(Q_DEPTH);
  localparam logic [CR_SZ-1:0] CR_ONE = CR_SZ'(1);
  localparam logic [CNT_SZ-1:0] C_ONE = CNT_SZ'(1);

  typedef enum logic [1:0] {
    IDLE, FETCH, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_SZ-1:0] b1_q, b2_q;
  logic [CNT_SZ-1:0]  rem1_q, rem2_q;
  logic [CNT_SZ-1:0]  off1_q, off2_q;
  logic [CNT_SZ-1:0]  rem1_n, rem2_n;
  logic [CR_SZ-1:0]   cr1_q, cr2_q;
  logic               ptr_q;
  logic               vld_q, tag_q, last_q;
  logic               err_q;
  logic               el1, el2, gnt1, gnt2;
  logic [GENE_SZ-1:0] rd_data;

  assign rd_data = bus.mem_rd_data;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start)
          state_d = (p1_len == '0 && p2_len == '0)
                  ? DONE : FETCH;
      FETCH:
        if (rem1_n == '0 && rem2_n == '0)
          state_d = DRAIN;
      // read latency is one cycle: the last read lands now
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == FETCH) || (state_q == DRAIN);
    done = (state_q == DONE);
    el1  = (state_q == FETCH) && rem1_q != '0
         && cr1_q != '0;
    el2  = (state_q == FETCH) && rem2_q != '0
         && cr2_q != '0;
    gnt1 = el1 && (!el2 || !ptr_q);
    gnt2 = el2 && !gnt1;
    rem1_n = rem1_q - CNT_SZ'(gnt1);
    rem2_n = rem2_q - CNT_SZ'(gnt2);
    bus.mem_rd_en = gnt1 || gnt2;
    unique case (1'b1)
      gnt1:    bus.mem_addr = b1_q + ADDR_SZ'(off1_q);
      gnt2:    bus.mem_addr = b2_q + ADDR_SZ'(off2_q);
      default: bus.mem_addr = '0;
    endcase
    bus.g1_wr   = vld_q && !tag_q;
    bus.g2_wr   = vld_q && tag_q;
    bus.g1_last = vld_q && !tag_q && last_q;
    bus.g2_last = vld_q && tag_q && last_q;
    bus.g1_data = rd_data;
    bus.g2_data = rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b1_q   <= '0;
      b2_q   <= '0;
      rem1_q <= '0;
      rem2_q <= '0;
      off1_q <= '0;
      off2_q <= '0;
      ptr_q  <= 1'b0;
      vld_q  <= 1'b0;
      tag_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= gnt1 || gnt2;
      tag_q  <= gnt2;
      last_q <= gnt1 ? (rem1_q == C_ONE)
                     : (rem2_q == C_ONE);
      if (state_q == IDLE && start) begin
        b1_q   <= p1_base;
        b2_q   <= p2_base;
        rem1_q <= p1_len;
        rem2_q <= p2_len;
        off1_q <= '0;
        off2_q <= '0;
        ptr_q  <= 1'b0;
      end
      if (gnt1) begin
        off1_q <= off1_q + C_ONE;
        rem1_q <= rem1_n;
      end
      if (gnt2) begin
        off2_q <= off2_q + C_ONE;
        rem2_q <= rem2_n;
      end
      if (el1 && el2) ptr_q <= gnt1;
    end
  end

  // a pop against a full credit pool is dropped and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      cr1_q <= CR_MAX;
      cr2_q <= CR_MAX;
      err_q <= 1'b0;
    end else begin
      unique case ({gnt1, bus.g1_pop})
        2'b10: cr1_q <= cr1_q - CR_ONE;
        2'b01:
          if (cr1_q == CR_MAX) err_q <= 1'b1;
          else cr1_q <= cr1_q + CR_ONE;
        default: ;
      endcase
      unique case ({gnt2, bus.g2_pop})
        2'b10: cr2_q <= cr2_q - CR_ONE;
        2'b01:
          if (cr2_q == CR_MAX) err_q <= 1'b1;
          else cr2_q <= cr2_q + CR_ONE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_gene_fetch_ctrl.sv
// Self-checking bench for pe_gene_fetch_ctrl against a
// job-level reference model with randomized consumer pops.
module tb_pe_gene_fetch_ctrl;
  localparam int GENE_SZ = 64;
  localparam int ADDR_SZ = 10;
  localparam int CNT_SZ  = 8;
  localparam int Q_DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [ADDR_SZ-1:0] p1_base, p2_base;
  logic [CNT_SZ-1:0] p1_len, p2_len;
  logic busy, done, err;

  pe_gene_fetch_ctrl_if #(
    .GENE_SZ(GENE_SZ), .ADDR_SZ(ADDR_SZ)
  ) bus ();

  pe_gene_fetch_ctrl #(
    .GENE_SZ(GENE_SZ), .ADDR_SZ(ADDR_SZ),
    .CNT_SZ(CNT_SZ), .Q_DEPTH(Q_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_base(p1_base), .p1_len(p1_len),
    .p2_base(p2_base), .p2_len(p2_len),
    .busy(busy), .done(done), .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [21:0] salt;

  function automatic logic [63:0] gene(input logic [9:0] a);
    return {a, salt, a, 22'h0ABCDE};
  endfunction

  // genome memory: data one cycle after the read strobe
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ? gene(bus.mem_addr) : '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model (states: 0 idle, 1 fetch, 2 drain, 3 done)
  int m_st;
  int m_rem[2];
  int m_off[2];
  int m_cr[2];
  int m_ptr;
  logic [9:0] m_base[2];
  bit m_err, m_vld, m_last;
  int m_tag;
  logic [9:0] m_raddr;

  int addr_log[$];
  int tag_log[$];
  int gcyc_log[$];
  int last_wr_cyc, done_cyc, start_cyc, g2_last_cnt;

  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_err = 0; m_vld = 0;
    m_tag = 0; m_last = 0;
    for (int i = 0; i < 2; i++) begin
      m_cr[i] = Q_DEPTH; m_rem[i] = 0; m_off[i] = 0;
    end
  endtask

  task automatic start_job(input logic [9:0] b1,
                           input logic [7:0] l1,
                           input logic [9:0] b2,
                           input logic [7:0] l2);
    @(negedge clk); cyc++;
    salt = 22'($urandom);
    p1_base = b1; p1_len = l1;
    p2_base = b2; p2_len = l2;
    start = 1'b1;
    bus.g1_pop = 1'b0; bus.g2_pop = 1'b0;
    addr_log.delete(); tag_log.delete(); gcyc_log.delete();
    last_wr_cyc = -1; done_cyc = -1; g2_last_cnt = 0;
    start_cyc = cyc;
    m_base[0] = b1; m_base[1] = b2;
    m_rem[0] = int'(l1); m_rem[1] = int'(l2);
    m_off[0] = 0; m_off[1] = 0; m_ptr = 0; m_vld = 0;
    m_st = (l1 == 0 && l2 == 0) ? 3 : 1;
  endtask

  task automatic run_cycles(input int n, input int pct,
                            input int pop_lim, input int junk_at,
                            output bit saw_done);
    int used, g;
    bit el0, el1, w1, w2;
    bit pop[2];
    logic [9:0] ea;
    used = 0; saw_done = 0;
    for (int k = 0; k < n && !saw_done; k++) begin
      @(negedge clk); cyc++;
      start = (k == junk_at);
      if (k == junk_at) begin
        p1_base = 10'($urandom); p1_len = 8'($urandom_range(1, 255));
        p2_base = 10'($urandom); p2_len = 8'($urandom_range(1, 255));
      end
      el0 = m_st == 1 && m_rem[0] > 0 && m_cr[0] > 0;
      el1 = m_st == 1 && m_rem[1] > 0 && m_cr[1] > 0;
      g = -1;
      if (el0 && el1) g = m_ptr;
      else if (el0) g = 0;
      else if (el1) g = 1;
      ea = 10'd0;
      if (g >= 0) ea = m_base[g] + 10'(m_off[g]);
      w1 = m_vld && m_tag == 0;
      w2 = m_vld && m_tag == 1;
      checks++;
      if (bus.mem_rd_en !== (g >= 0)) begin errors++;
        $display("FAIL rd_en cyc%0d got %b want %b", cyc, bus.mem_rd_en, g >= 0); end
      if (g >= 0) begin
        checks++;
        if (bus.mem_addr !== ea) begin errors++;
          $display("FAIL addr cyc%0d got %h want %h", cyc, bus.mem_addr, ea); end
      end
      checks++;
      if (bus.g1_wr !== w1 || bus.g2_wr !== w2) begin errors++;
        $display("FAIL wr cyc%0d got %b%b want %b%b", cyc, bus.g1_wr, bus.g2_wr, w1, w2); end
      checks++;
      if (bus.g1_last !== (w1 && m_last) || bus.g2_last !== (w2 && m_last)) begin errors++;
        $display("FAIL last cyc%0d got %b%b want %b%b", cyc, bus.g1_last, bus.g2_last,
                 w1 && m_last, w2 && m_last); end
      if (w1) begin
        checks++;
        if (bus.g1_data !== gene(m_raddr)) begin errors++;
          $display("FAIL g1_data cyc%0d got %h want %h", cyc, bus.g1_data, gene(m_raddr)); end
      end
      if (w2) begin
        checks++;
        if (bus.g2_data !== gene(m_raddr)) begin errors++;
          $display("FAIL g2_data cyc%0d got %h want %h", cyc, bus.g2_data, gene(m_raddr)); end
      end
      checks++;
      if (busy !== (m_st == 1 || m_st == 2) || done !== (m_st == 3)) begin errors++;
        $display("FAIL busy/done cyc%0d got %b%b want %b%b", cyc, busy, done,
                 m_st == 1 || m_st == 2, m_st == 3); end
      checks++;
      if (err !== m_err) begin errors++;
        $display("FAIL err cyc%0d got %b want %b", cyc, err, m_err); end
      if (g >= 0) begin
        addr_log.push_back(int'(ea)); tag_log.push_back(g); gcyc_log.push_back(cyc);
      end
      if (bus.g1_wr === 1'b1 || bus.g2_wr === 1'b1) last_wr_cyc = cyc;
      if (done === 1'b1) done_cyc = cyc;
      if (bus.g2_wr === 1'b1 && bus.g2_last === 1'b1) g2_last_cnt++;
      saw_done = (m_st == 3);
      for (int i = 0; i < 2; i++) begin
        pop[i] = used < pop_lim && m_cr[i] < Q_DEPTH
              && $urandom_range(99) < pct;
        if (pop[i]) used++;
      end
      bus.g1_pop = pop[0]; bus.g2_pop = pop[1];
      m_vld = g >= 0;
      if (g >= 0) begin
        m_tag = g; m_last = m_rem[g] == 1; m_raddr = ea;
        m_off[g]++; m_rem[g]--;
        if (el0 && el1) m_ptr = 1 - g;
      end
      for (int i = 0; i < 2; i++) begin
        if (pop[i] && m_cr[i] == Q_DEPTH && g != i) m_err = 1;
        else m_cr[i] = m_cr[i] - int'(g == i) + int'(pop[i]);
      end
      case (m_st)
        1: if (m_rem[0] == 0 && m_rem[1] == 0) m_st = 2;
        2: m_st = 3;
        3: m_st = 0;
        default: ;
      endcase
    end
  endtask

  task automatic drain();
    bit d;
    run_cycles(12, 100, 99, -1, d);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    cyc += 3;
    checks++;
    if ({busy, done, err} !== 3'b000) begin errors++;
      $display("FAIL reset_ctl got %b want 000", {busy, done, err}); end
    checks++;
    if (bus.mem_rd_en !== 1'b0) begin errors++;
      $display("FAIL reset_rd_en got %b want 0", bus.mem_rd_en); end
    checks++;
    if (bus.mem_addr !== '0) begin errors++;
      $display("FAIL reset_addr got %h want 0", bus.mem_addr); end
    checks++;
    if ({bus.g1_wr, bus.g2_wr, bus.g1_last, bus.g2_last} !== 4'b0) begin errors++;
      $display("FAIL reset_q got %b want 0000",
               {bus.g1_wr, bus.g2_wr, bus.g1_last, bus.g2_last}); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_two_parents();
    int exp_a[6] = '{'h010, 'h100, 'h011, 'h101, 'h012, 'h102};
    bit d;
    start_job(10'h010, 8'd3, 10'h100, 8'd3);
    run_cycles(40, 100, 999, -1, d);
    checks++;
    if (addr_log.size() != 6 || !d) begin errors++;
      $display("FAIL tp_count got %0d/%b want 6/1", addr_log.size(), d); end
    for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] != exp_a[i] || gcyc_log[i] != start_cyc + 1 + i) begin errors++;
        $display("FAIL tp_seq%0d got %h@%0d want %h@%0d", i, addr_log[i],
                 gcyc_log[i], exp_a[i], start_cyc + 1 + i); end
    end
    checks++;
    if (done_cyc != start_cyc + 8 || last_wr_cyc != start_cyc + 7) begin errors++;
      $display("FAIL tp_done got %0d/%0d want %0d/%0d", done_cyc - start_cyc,
               last_wr_cyc - start_cyc, 8, 7); end
  endtask

  task automatic test_zero_len();
    bit d;
    start_job(10'($urandom), 8'd0, 10'($urandom), 8'd0);
    run_cycles(4, 50, 99, -1, d);
    checks++;
    if (done_cyc != start_cyc + 1 || addr_log.size() != 0) begin errors++;
      $display("FAIL zero_len got done@%0d reads %0d want done@1 reads 0",
               done_cyc - start_cyc, addr_log.size()); end
  endtask

  task automatic test_rr_imbalance();
    int exp_t[5] = '{0, 1, 1, 1, 1};
    bit d;
    start_job(10'($urandom), 8'd1, 10'($urandom), 8'd4);
    run_cycles(40, 100, 999, -1, d);
    checks++;
    if (tag_log.size() != 5 || g2_last_cnt != 1) begin errors++;
      $display("FAIL rr_count got %0d/%0d want 5/1", tag_log.size(), g2_last_cnt); end
    for (int i = 0; i < 5 && i < tag_log.size(); i++) begin
      checks++;
      if (tag_log[i] != exp_t[i] || gcyc_log[i] != start_cyc + 1 + i) begin errors++;
        $display("FAIL rr_order%0d got p%0d@%0d want p%0d@%0d", i, tag_log[i] + 1,
                 gcyc_log[i], exp_t[i] + 1, start_cyc + 1 + i); end
    end
  endtask

  task automatic test_addr_wrap();
    int exp_a[4] = '{'h3FE, 'h3FF, 'h000, 'h001};
    bit d;
    start_job(10'h3FE, 8'd4, 10'($urandom), 8'd0);
    run_cycles(40, 100, 999, -1, d);
    checks++;
    if (addr_log.size() != 4 || !d) begin errors++;
      $display("FAIL wrap_count got %0d/%b want 4/1", addr_log.size(), d); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] != exp_a[i]) begin errors++;
        $display("FAIL wrap%0d got %h want %h", i, addr_log[i], exp_a[i]); end
    end
  endtask

  task automatic test_start_ignored();
    bit d;
    start_job(10'($urandom), 8'd6, 10'($urandom), 8'd6);
    run_cycles(300, 60, 999, 2, d);
    checks++;
    if (!d || addr_log.size() != 12) begin errors++;
      $display("FAIL start_ign got %b/%0d want 1/12", d, addr_log.size()); end
  endtask

  task automatic test_reset_mid_job();
    bit d;
    start_job(10'h040, 8'd6, 10'h080, 8'd6);
    run_cycles(3, 100, 99, -1, d);
    rst = 1'b1; bus.g1_pop = 1'b0; bus.g2_pop = 1'b0;
    @(negedge clk); cyc++;
    checks++;
    if ({bus.g1_wr, bus.g2_wr, busy, done} !== 4'b0) begin errors++;
      $display("FAIL mid_rst got %b want 0000",
               {bus.g1_wr, bus.g2_wr, busy, done}); end
    rst = 1'b0;
    model_reset();
    bus.g1_pop = 1'b1;
    @(negedge clk); cyc++;
    bus.g1_pop = 1'b0;
    m_err = 1;
    checks++;
    if (err !== 1'b1) begin errors++;
      $display("FAIL err_set got %b want 1", err); end
    start_job(10'($urandom), 8'd2, 10'($urandom), 8'd1);
    run_cycles(30, 100, 99, -1, d);
    drain();
    @(negedge clk); cyc++;
    rst = 1'b1;
    @(negedge clk); cyc++;
    rst = 1'b0;
    model_reset();
    checks++;
    if (err !== 1'b0) begin errors++;
      $display("FAIL err_clr got %b want 0", err); end
  endtask

  task automatic test_credit_stall();
    logic [9:0] b;
    bit d;
    b = 10'($urandom);
    start_job(b, 8'd12, 10'($urandom), 8'd0);
    run_cycles(20, 0, 0, -1, d);
    checks++;
    if (addr_log.size() != 8 || d) begin errors++;
      $display("FAIL stall8 got %0d/%b want 8/0", addr_log.size(), d); end
    run_cycles(6, 100, 1, -1, d);
    checks++;
    if (addr_log.size() != 9 || addr_log[addr_log.size() - 1] != int'(b + 10'd8)) begin
      errors++;
      $display("FAIL stall_pop1 got %0d reads want 9 at %h", addr_log.size(), b + 10'd8);
    end
    run_cycles(10, 100, 2, -1, d);
    checks++;
    if (addr_log.size() != 11 || d) begin errors++;
      $display("FAIL stall_pop3 got %0d/%b want 11/0", addr_log.size(), d); end
    run_cycles(10, 100, 1, -1, d);
    checks++;
    if (addr_log.size() != 12 || !d) begin errors++;
      $display("FAIL stall_pop4 got %0d/%b want 12/1", addr_log.size(), d); end
  endtask

  task automatic test_random();
    bit d;
    for (int j = 0; j < 8; j++) begin
      start_job(10'($urandom), 8'($urandom_range(0, 20)),
                10'($urandom), 8'($urandom_range(0, 20)));
      run_cycles(600, $urandom_range(20, 100), 999, -1, d);
      checks++;
      if (!d) begin errors++;
        $display("FAIL rand_job%0d got no done want done", j); end
      drain();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    p1_base = '0; p2_base = '0; p1_len = '0; p2_len = '0;
    bus.g1_pop = 1'b0; bus.g2_pop = 1'b0;
    salt = '0;
    test_reset();
    test_two_parents();
    drain();
    test_zero_len();
    test_rr_imbalance();
    drain();
    test_addr_wrap();
    drain();
    test_start_ignored();
    drain();
    test_reset_mid_job();
    test_credit_stall();
    drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_gene_fetch_ctrl.md
Name: pe_gene_fetch_ctrl

Overview:
- Fetch sequencer for the PE gene-alignment front end.
- Shares a single genome-memory read port between two parent gene streams (parent 1, parent 2). Pushes each parent's genes, in address order, into that parent's gene queue.
- Uses per-queue credit flow control and round-robin arbitration.
- Signals `busy`/`done` so the PE scheduler can sequence crossover jobs.

Parameters:
- GENE_SZ, 64, gene word width
- ADDR_SZ, 10, genome memory address width
- CNT_SZ, 8, gene-count width per parent
- Q_DEPTH, 8, entries per gene queue (initial credit count)

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  launch job; sampled only in IDLE
- p1_base  in  ADDR_SZ  parent-1 first gene address
- p1_len  in  CNT_SZ  parent-1 gene count
- p2_base  in  ADDR_SZ  parent-2 first gene address
- p2_len  in  CNT_SZ  parent-2 gene count
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- err  out  1  sticky credit-overflow flag
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_SZ  memory read address
- mem_rd_data  in  GENE_SZ  read data, valid exactly 1 cycle after mem_rd_en
- g1_pop  in  1  queue-1 consumer dequeued one entry (credit return)
- g2_pop  in  1  queue-2 consumer dequeued one entry (credit return)
- g1_wr  out  1  write strobe into queue 1
- g1_data  out  GENE_SZ  queue-1 write data
- g1_last  out  1  final parent-1 gene, qualified by g1_wr
- g2_wr  out  1  write strobe into queue 2
- g2_data  out  GENE_SZ  queue-2 write data
- g2_last  out  1  final parent-2 gene, qualified by g2_wr

Behaviour:

Reset
- `busy`, `done`, `err`, `mem_rd_en`, `g1_wr`, `g2_wr`, `g1_last`, `g2_last` = 0.
- `mem_addr` = 0. State = IDLE. Credits = Q_DEPTH. Outstanding-read tag cleared.
- Reset mid-job aborts the job. In-flight read data is discarded: no `gX_wr` the cycle after reset.

States: IDLE, FETCH, DRAIN, DONE.

IDLE
- `busy` = 0.
- On `start`: latch bases and lengths, zero the offset counters, point the round-robin pointer at parent 1.
  - Both lengths 0 → DONE.
  - Otherwise → FETCH.

FETCH (`busy` = 1)
- Parent i is eligible when remaining_i > 0 and credit_i > 0.
- Both eligible: grant the pointer's parent, then move the pointer to the other parent.
- One eligible: grant it; pointer unchanged.
- Grant issues `mem_rd_en` = 1, `mem_addr` = base_i + offset_i (modulo 2^ADDR_SZ, wraps silently).
  - offset_i++, remaining_i--, credit_i--.
  - Records tag = i and last = (remaining_i was 1).
- No eligible parent (credit stall): `mem_rd_en` = 0, remain in FETCH.
- Both remaining = 0 after the cycle's grant → DRAIN.

Data return (any state)
- Cycle after a grant: `gX_wr` = 1 for the tagged parent, `gX_data` = `mem_rd_data`, `gX_last` = recorded last.
- At most one of `g1_wr`/`g2_wr` per cycle.
- Sustained throughput: one gene per cycle.

DRAIN (`busy` = 1)
- Wait until no read is outstanding → DONE.

DONE
- `done` = 1 and `busy` = 0 for exactly one cycle → IDLE.
- `done` occurs the cycle after the final `gX_wr`, or the cycle after `start` for a zero-length job.

Credits
- credit_i = credit_i − grant_i + pop_i; grant and pop in the same cycle leave it unchanged.
- A pop with credit_i already at Q_DEPTH (and no grant) is ignored and sets `err`. `err` clears only on rst.
- Pops are accepted in every state, including IDLE. Credits persist across jobs and reset only on rst.

Other
- `start` while not in IDLE is ignored.
- Lengths and bases are not re-sampled mid-job.

Test Plan:
1. Q_DEPTH=8, p1_base=0x010 len 3, p2_base=0x100 len 3, pops tied high → `mem_addr` sequence 010,100,011,101,012,102 on consecutive cycles; `g1_last` with the third g1 write, `g2_last` with the third g2 write; `done` one cycle after the write of 0x102 data.
2. p1 len 12, p2 len 0, no pops → exactly 8 reads, then `mem_rd_en` held 0. Single `g1_pop` → exactly one more read (addr base+8). Job completes only after 4 pops total.
3. Both lengths 0 → no `mem_rd_en`; `done` pulse the cycle after `start`; `busy` never asserts.
4. p1 len 1, p2 len 4, ample credits → grant order P1,P2,P2,P2,P2 back-to-back; `g2_last` only on the 4th g2 write.
5. ADDR_SZ=10, p1_base=0x3FE len 4 → addresses 3FE,3FF,000,001.
6. `start` pulsed during FETCH → ignored. rst asserted mid-job with a read outstanding → next cycle no `gX_wr`, `busy`=0, credits=8. `g1_pop` at full credit → `err`=1 and stays 1 until rst.
